// File: rtl/blake2_pkg.sv
// blake2_pkg: shared FSM state type and block geometry for the BLAKE2 block feeder.
package blake2_pkg;

    typedef enum logic [1:0] {FILL, FULL, ISSUE, WAIT} state_t;

    localparam int BLOCK_WORDS    = 16;
    localparam int W_DEFAULT      = 64;
    localparam int BYTES_PER_WORD = W_DEFAULT / 8;

    function automatic int bytes_per_word(input int w);
        return w / 8;
    endfunction

endpackage

// File: rtl/blake2_byte_mask.sv
// blake2_byte_mask: keep-mask with ones in every byte lane below nbytes.
module blake2_byte_mask #(
    parameter int W = 64
) (
    input  logic [$clog2(W/8):0] nbytes,
    output logic [W-1:0]         mask
);

    localparam int NBW = $clog2(W/8) + 1;

    for (genvar b = 0; b < W/8; b++) begin : g_lane
        assign mask[8*b +: 8] = {8{nbytes > NBW'(b)}};
    end

endmodule

// File: rtl/blake2_block_feeder.sv
// blake2_block_feeder: packs message words into padded 16-word blocks, issues them
// with byte counter and final flag to a BLAKE2 core, and registers the final digest.
module blake2_block_feeder
    import blake2_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int NN = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [W-1:0]          data_i,
    input  logic                  last_i,
    input  logic [$clog2(W/8):0]  nbytes_i,
    output logic                  blk_valid_o,
    output logic [16*W-1:0]       block_o,
    output logic [2*W-1:0]        t_o,
    output logic                  f_o,
    input  logic                  core_valid_i,
    input  logic [NN*8-1:0]       core_h_i,
    output logic                  digest_valid_o,
    output logic [NN*8-1:0]       digest_o
);

    localparam int BPW = bytes_per_word(W);

    state_t                       state;
    logic [3:0]                   wcnt;
    logic [2*W-1:0]               t, t_n;
    logic [BLOCK_WORDS*W-1:0]     blk_buf, blk_n;
    logic [W-1:0]                 mask, word;
    logic                         accept;

    blake2_byte_mask #(.W(W)) u_mask (
        .nbytes (nbytes_i),
        .mask   (mask)
    );

    assign ready_o = (state == FILL);
    assign accept  = valid_i & ready_o;
    assign word    = data_i & (last_i ? mask : '1);
    assign t_n     = t + (last_i ? (2*W)'(nbytes_i) : (2*W)'(BPW));

    always_comb begin
        blk_n = blk_buf;
        blk_n[W*wcnt +: W] = word;
    end

    // block_o/t_o/f_o are separate registers so they stay stable while the
    // working buffer is cleared and refilled for the next block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= FILL;
            wcnt           <= '0;
            t              <= '0;
            blk_buf        <= '0;
            block_o        <= '0;
            t_o            <= '0;
            f_o            <= 1'b0;
            blk_valid_o    <= 1'b0;
            digest_valid_o <= 1'b0;
            digest_o       <= '0;
        end else begin
            blk_valid_o    <= 1'b0;
            digest_valid_o <= 1'b0;
            case (state)
                FILL: if (accept) begin
                    blk_buf <= blk_n;
                    t       <= t_n;
                    wcnt    <= wcnt + 4'd1;
                    if (last_i) begin
                        state       <= ISSUE;
                        block_o     <= blk_n;
                        t_o         <= t_n;
                        f_o         <= 1'b1;
                        blk_valid_o <= 1'b1;
                    end else if (wcnt == 4'(BLOCK_WORDS-1)) begin
                        state <= FULL;
                    end
                end
                FULL: if (valid_i) begin
                    state       <= ISSUE;
                    block_o     <= blk_buf;
                    t_o         <= t;
                    f_o         <= 1'b0;
                    blk_valid_o <= 1'b1;
                end
                ISSUE: state <= WAIT;
                WAIT: if (core_valid_i) begin
                    if (f_o) begin
                        digest_o       <= core_h_i;
                        digest_valid_o <= 1'b1;
                        t              <= '0;
                    end
                    wcnt    <= '0;
                    blk_buf <= '0;
                    state   <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_blake2_block_feeder.sv
// tb_blake2_block_feeder: directed self-checking bench for blake2_block_feeder (W=64, NN=64).
module tb_blake2_block_feeder;

    localparam int W  = 64;
    localparam int NN = 64;

    logic              clk, reset, valid_i, ready_o, last_i;
    logic [W-1:0]      data_i;
    logic [3:0]        nbytes_i;
    logic              blk_valid_o, f_o, core_valid_i, digest_valid_o;
    logic [16*W-1:0]   block_o;
    logic [2*W-1:0]    t_o;
    logic [NN*8-1:0]   core_h_i, digest_o;

    int checks = 0;
    int errors = 0;
    int nblk   = 0;

    blake2_block_feeder #(.W(W), .NN(NN)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .data_i         (data_i),
        .last_i         (last_i),
        .nbytes_i       (nbytes_i),
        .blk_valid_o    (blk_valid_o),
        .block_o        (block_o),
        .t_o            (t_o),
        .f_o            (f_o),
        .core_valid_i   (core_valid_i),
        .core_h_i       (core_h_i),
        .digest_valid_o (digest_valid_o),
        .digest_o       (digest_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (blk_valid_o) nblk <= nblk + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_block(input string tag, input logic [16*W-1:0] exp);
        for (int k = 0; k < 16; k++)
            chk($sformatf("%s_w%0d", tag, k), 128'(block_o[64*k +: 64]), 128'(exp[64*k +: 64]));
    endtask

    task automatic chk_digest(input string tag, input logic [NN*8-1:0] exp);
        for (int k = 0; k < NN/8; k++)
            chk($sformatf("%s_d%0d", tag, k), 128'(digest_o[64*k +: 64]), 128'(exp[64*k +: 64]));
    endtask

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic send(input logic [63:0] d, input logic l, input logic [3:0] nb);
        int n = 0;
        valid_i  = 1'b1;
        data_i   = d;
        last_i   = l;
        nbytes_i = nb;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 50) else begin
            errors++;
            $error("FAIL send_timeout: observed %0d cycles required < 50", n);
        end
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    // Called at the negedge of the ISSUE cycle.
    task automatic finish_block(input string tag, input logic [16*W-1:0] eb,
                                input logic [127:0] et, input logic ef,
                                input logic [NN*8-1:0] h);
        chk({tag, "_blkv"}, 128'(blk_valid_o), 128'(1));
        chk({tag, "_t"}, t_o, et);
        chk({tag, "_f"}, 128'(f_o), 128'(ef));
        chk({tag, "_rdy_issue"}, 128'(ready_o), 128'(0));
        chk_block(tag, eb);
        @(negedge clk);
        chk({tag, "_blkv_wait"}, 128'(blk_valid_o), 128'(0));
        chk({tag, "_rdy_wait"}, 128'(ready_o), 128'(0));
        chk({tag, "_t_hold"}, t_o, et);
        core_valid_i = 1'b1;
        core_h_i     = h;
        @(negedge clk);
        core_valid_i = 1'b0;
        chk({tag, "_dv"}, 128'(digest_valid_o), 128'(ef));
        chk({tag, "_rdy_back"}, 128'(ready_o), 128'(1));
        if (ef) chk_digest(tag, h);
        @(negedge clk);
        chk({tag, "_dv_end"}, 128'(digest_valid_o), 128'(0));
    endtask

    logic [16*W-1:0] eb;
    logic [NN*8-1:0] h;

    initial begin
        reset = 1'b1; valid_i = 1'b0; last_i = 1'b0; data_i = '0; nbytes_i = '0;
        core_valid_i = 1'b0; core_h_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(ready_o), 128'(1));
        chk("rst_blkv", 128'(blk_valid_o), 128'(0));
        chk("rst_t", t_o, 128'(0));
        chk("rst_f", 128'(f_o), 128'(0));
        chk("rst_dv", 128'(digest_valid_o), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        core_valid_i = 1'b1; core_h_i = {8{64'hbadbadbadbadbad0}};
        @(negedge clk);
        core_valid_i = 1'b0;
        chk("ign_core_dv", 128'(digest_valid_o), 128'(0));
        chk("ign_core_rdy", 128'(ready_o), 128'(1));
        @(negedge clk);
        chk("ign_core_dv2", 128'(digest_valid_o), 128'(0));

        send(64'h636261, 1'b1, 4'd3);
        eb = '0; eb[63:0] = 64'h0000000000636261;
        h = {8{64'h1122334455667788}};
        finish_block("abc", eb, 128'd3, 1'b1, h);

        send(64'h0, 1'b1, 4'd0);
        eb = '0;
        h = {8{64'hfedcba9876543210}};
        finish_block("empty", eb, 128'd0, 1'b1, h);

        send(64'h1122334455667788, 1'b0, 4'd0);
        send(64'hdeadbeefcafef00d, 1'b1, 4'd5);
        eb = '0; eb[63:0] = 64'h1122334455667788; eb[127:64] = 64'h000000efcafef00d;
        h = {4{128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0}};
        finish_block("mask5", eb, 128'd13, 1'b1, h);

        send(64'ha5a5a5a5a5a5a5a5, 1'b0, 4'd0);
        send(64'hffffffffffffffff, 1'b1, 4'd0);
        eb = '0; eb[63:0] = 64'ha5a5a5a5a5a5a5a5;
        h = {8{64'h0102030405060708}};
        finish_block("zlast", eb, 128'd8, 1'b1, h);

        eb = '0;
        for (int k = 0; k < 16; k++) begin
            eb[64*k +: 64] = 64'h0123456789abcdef + 64'(k);
            send(64'h0123456789abcdef + 64'(k), k == 15, 4'd8);
        end
        h = {8{64'h5555aaaa5555aaaa}};
        finish_block("exact128", eb, 128'd128, 1'b1, h);

        for (int k = 0; k < 16; k++)
            send(64'h0123456789abcdef + 64'(k), 1'b0, 4'd8);
        chk("full_rdy", 128'(ready_o), 128'(0));
        chk("full_blkv", 128'(blk_valid_o), 128'(0));
        @(negedge clk);
        chk("full_rdy2", 128'(ready_o), 128'(0));
        chk("full_blkv2", 128'(blk_valid_o), 128'(0));
        valid_i = 1'b1; data_i = 64'haaaaaaaaaaaaaa42; last_i = 1'b1; nbytes_i = 4'd1;
        @(negedge clk);
        h = {8{64'h0}};
        finish_block("b129_1", eb, 128'd128, 1'b0, h);
        valid_i = 1'b0; last_i = 1'b0;
        eb = '0; eb[63:0] = 64'h42;
        h = {8{64'h8877665544332211}};
        finish_block("b129_2", eb, 128'd129, 1'b1, h);

        for (int k = 0; k < 5; k++)
            send(64'h1111111111111111 * 64'(k + 1), 1'b0, 4'd8);
        reset = 1'b1;
        #1;
        chk("mrst_blkv", 128'(blk_valid_o), 128'(0));
        chk("mrst_t", t_o, 128'(0));
        chk("mrst_f", 128'(f_o), 128'(0));
        chk("mrst_dv", 128'(digest_valid_o), 128'(0));
        chk_digest("mrst", '0);
        chk_block("mrst", '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_ready", 128'(ready_o), 128'(1));
        send(64'h636261, 1'b1, 4'd3);
        eb = '0; eb[63:0] = 64'h636261;
        h = {8{64'h0badc0de0badc0de}};
        finish_block("abc2", eb, 128'd3, 1'b1, h);

        chk("pulse_count", 128'(nblk), 128'(8));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blake2_block_feeder.md
BLAKE2_BLOCK_FEEDER -- requirements
Module: blake2_block_feeder

Interface
REQ-001 SHALL have parameter W, default 64, giving the word width in bits (64 = blake2b, 32 = blake2s).
REQ-002 SHALL have parameter NN, default 64, giving the digest size in bytes; the digest port width is NN*8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port valid_i, input, 1 bit: the message word on data_i is valid.
REQ-006 SHALL have port ready_o, output, 1 bit: the block accepts the word this cycle.
REQ-007 SHALL have port data_i, input, W bits: message word, little-endian (byte 0 in bits [7:0]).
REQ-008 SHALL have port last_i, input, 1 bit: data_i is the final word of the message.
REQ-009 SHALL have port nbytes_i, input, log2(W/8)+1 bits: number of valid bytes in the last word (0..W/8); ignored unless last_i=1.
REQ-010 SHALL have port blk_valid_o, output, 1 bit: one-cycle pulse meaning block_o, t_o and f_o are issued to the hash core.
REQ-011 SHALL have port block_o, output, 16*W bits: the padded message block; word k sits in [W*k +: W].
REQ-012 SHALL have port t_o, output, 2*W bits: the byte offset counter, including this block.
REQ-013 SHALL have port f_o, output, 1 bit: final-block flag.
REQ-014 SHALL have port core_valid_i, input, 1 bit: the hash core has finished the issued block.
REQ-015 SHALL have port core_h_i, input, NN*8 bits: the hash core result.
REQ-016 SHALL have port digest_valid_o, output, 1 bit: one-cycle pulse marking a valid digest_o.
REQ-017 SHALL have port digest_o, output, NN*8 bits: the registered final digest.

Function
REQ-018 SHALL implement FSM states FILL, FULL, ISSUE, WAIT.
REQ-019 SHALL assert ready_o only in FILL; a word is accepted when valid_i & ready_o.
REQ-020 SHALL write each accepted word into slot wcnt (0..15), increment wcnt, and add W/8 to t; on a last word it SHALL add nbytes_i instead.
REQ-021 SHALL zero the bytes at index >= nbytes_i in the last word, and zero all slots after it.
REQ-022 FILL SHALL go to ISSUE with f=1 when last_i is accepted, including on slot 15.
REQ-023 FILL SHALL go to FULL when slot 15 is accepted without last_i.
REQ-024 FULL SHALL keep ready_o=0 and peek valid_i; valid_i=1 SHALL cause ISSUE with f=0, leaving that word pending on the interface.
REQ-025 ISSUE SHALL pulse blk_valid_o for exactly one cycle, then go to WAIT; block_o, t_o and f_o SHALL be held stable from ISSUE until the next issue.
REQ-026 WAIT SHALL exit on core_valid_i: with f=1 it SHALL register digest_o <= core_h_i, pulse digest_valid_o the next cycle, and clear t; with f=0 it SHALL keep t. Either way it SHALL clear wcnt and the block buffer, then go to FILL.
REQ-027 SHALL ignore core_valid_i outside WAIT.
REQ-028 An empty message (last_i with nbytes_i=0 as the first word) SHALL issue an all-zero block with t=0 and f=1.
REQ-029 t SHALL be a 2*W-bit counter that wraps modulo 2^(2W).
REQ-030 A last word with nbytes_i=0 that is not the first word SHALL be treated as a zero-byte word: the slot is zeroed and t is unchanged.
REQ-031 Latency: blk_valid_o SHALL rise one cycle after the completing accept, or one cycle after valid_i is seen in FULL.

Reset
REQ-032 reset SHALL force, asynchronously: FSM=FILL, wcnt=0, t=0, block buffer=0, f_o=0, blk_valid_o=0, digest_valid_o=0, digest_o=0, ready_o=1 after release.
REQ-033 Reset mid-operation SHALL discard the partial block and any outstanding core request without emitting a pulse.

Structure
REQ-034 Package blake2_pkg SHALL hold the state enum, BLOCK_WORDS=16, and BYTES_PER_WORD=W/8.
REQ-035 A sub-module blake2_byte_mask SHALL generate the W-bit keep-mask from nbytes_i.

Verification
REQ-036 Scenario "abc": data_i=0x636261, last_i=1, nbytes_i=3 -> block_o word0=0x0000000000636261, other words 0, t_o=3, f_o=1.
REQ-037 Scenario empty: last_i=1, nbytes_i=0 -> block_o all zero, t_o=0, f_o=1, one blk_valid_o pulse.
REQ-038 Scenario 129 bytes: 16 full words, then valid_i held -> block 1 with t_o=128, f_o=0; core_valid_i; 1-byte last word -> block 2 with t_o=129, f_o=1.
REQ-039 Scenario exact 128 bytes: last_i on word 16 -> single block with t_o=128, f_o=1; no FULL stall.
REQ-040 Scenario backpressure/digest: ready_o=0 throughout WAIT; core_valid_i with core_h_i=X -> digest_o=X and digest_valid_o high one cycle later.
REQ-041 Scenario reset: reset asserted after 5 words -> outputs cleared immediately; a new "abc" message then issues block_o word0=0x636261 with t_o=3.
